key_conditioner: RTL and testbench



---
 rtl/key_conditioner.sv | 227 ++++++++++++++++++++++
 tb/tb_key_conditioner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Push-button front end: synchronises, debounces and edge-detects Up/Down/Accel,
// generates hold-to-repeat pulses and the speed selection. Define KEY_LONGPRESS_CLR_EN for the Accel long-press clear.
module key_conditioner #(
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned REP_DELAY  = 25000000,
    parameter int unsigned REP_PERIOD = 5000000
) (
    input  logic       Clk_50MHz,
    input  logic       Rst_n,
    input  logic [2:0] Key_n,
    output logic [2:0] Key_level,
    output logic       Up_pulse,
    output logic       Down_pulse,
    output logic       Accel_pulse,
    output logic [1:0] Speed_sel,
    output logic [2:0] ALed,
    output logic       Clr_pulse
);

    localparam int unsigned DW      = $clog2(DEB_CYCLES);
    localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int unsigned RW      = $clog2(REP_MAX);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REP_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } rep_state_t;

    typedef enum logic [1:0] {
        SPD_1X = 2'd0,
        SPD_2X = 2'd1,
        SPD_4X = 2'd2
    } speed_t;

    // Synchroniser and debounce state; bit 0 Up, bit 1 Down, bit 2 Accel (1 = released).
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_stable;
    logic [2:0]    r_stable_d;
    logic [DW-1:0] r_deb_cnt [3];

    logic [2:0] w_level;
    logic [2:0] w_press;
    logic       w_both;

    always_ff @(posedge Clk_50MHz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sync1    <= '1;
            r_sync2    <= '1;
            r_stable   <= '1;
            r_stable_d <= '1;
            for (int unsigned i = 0; i < 3; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_sync1    <= Key_n;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            for (int unsigned i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_stable[i]  <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_level = ~r_stable;
    assign w_press = r_stable_d & ~r_stable;
    assign w_both  = w_level[0] & w_level[1];

    // Repeat FSMs: index 0 Up, index 1 Down.
    rep_state_t    r_state      [2];
    rep_state_t    w_state_nxt  [2];
    logic [RW-1:0] r_rcnt       [2];
    logic [RW-1:0] w_rcnt_nxt   [2];
    logic [1:0]    r_rep_pulse;
    logic [1:0]    w_rep_pulse_nxt;

    always_ff @(posedge Clk_50MHz or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned k = 0; k < 2; k++) begin
                r_state[k] <= S_IDLE;
                r_rcnt[k]  <= '0;
            end
            r_rep_pulse <= '0;
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                r_state[k] <= w_state_nxt[k];
                r_rcnt[k]  <= w_rcnt_nxt[k];
            end
            r_rep_pulse <= w_rep_pulse_nxt;
        end
    end

    // Holding both directions parks both FSMs in IDLE; since a press edge is
    // needed to leave IDLE, neither re-arms until released and pressed again.
    always_comb begin
        w_rep_pulse_nxt = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            w_state_nxt[k] = r_state[k];
            w_rcnt_nxt[k]  = r_rcnt[k];
            if (w_both) begin
                w_state_nxt[k] = S_IDLE;
                w_rcnt_nxt[k]  = '0;
            end else begin
                case (r_state[k])
                    S_IDLE: begin
                        if (w_press[k]) begin
                            w_rep_pulse_nxt[k] = 1'b1;
                            w_state_nxt[k]     = S_DELAY;
                            w_rcnt_nxt[k]      = '0;
                        end
                    end
                    S_DELAY: begin
                        if (!w_level[k]) begin
                            w_state_nxt[k] = S_IDLE;
                            w_rcnt_nxt[k]  = '0;
                        end else if (r_rcnt[k] == DLY_LAST) begin
                            w_rep_pulse_nxt[k] = 1'b1;
                            w_state_nxt[k]     = S_REPEAT;
                            w_rcnt_nxt[k]      = '0;
                        end else begin
                            w_rcnt_nxt[k] = r_rcnt[k] + 1'b1;
                        end
                    end
                    S_REPEAT: begin
                        if (!w_level[k]) begin
                            w_state_nxt[k] = S_IDLE;
                            w_rcnt_nxt[k]  = '0;
                        end else if (r_rcnt[k] == PER_LAST) begin
                            w_rep_pulse_nxt[k] = 1'b1;
                            w_rcnt_nxt[k]      = '0;
                        end else begin
                            w_rcnt_nxt[k] = r_rcnt[k] + 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt[k] = S_IDLE;
                        w_rcnt_nxt[k]  = '0;
                    end
                endcase
            end
        end
    end

    logic w_clr_nxt;

`ifdef KEY_LONGPRESS_CLR_EN
    localparam int unsigned   HW        = $clog2(2 * REP_DELAY + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(2 * REP_DELAY - 1);

    logic [HW-1:0] r_hold_cnt;

    // Counter parks one past the target so only one clear fires per hold.
    always_ff @(posedge Clk_50MHz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_hold_cnt <= '0;
        end else if (!w_level[2]) begin
            r_hold_cnt <= '0;
        end else if (r_hold_cnt <= HOLD_LAST) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    assign w_clr_nxt = w_level[2] && (r_hold_cnt == HOLD_LAST);
`else
    assign w_clr_nxt = 1'b0;
`endif

    speed_t     r_speed;
    speed_t     w_speed_nxt;
    logic [2:0] r_aled;
    logic [2:0] w_aled_nxt;
    logic       r_accel_pulse;
    logic       r_clr_pulse;

    always_comb begin
        w_speed_nxt = r_speed;
        if (w_clr_nxt) begin
            w_speed_nxt = SPD_1X;
        end else if (w_press[2]) begin
            case (r_speed)
                SPD_1X:  w_speed_nxt = SPD_2X;
                SPD_2X:  w_speed_nxt = SPD_4X;
                default: w_speed_nxt = SPD_1X;
            endcase
        end
        case (w_speed_nxt)
            SPD_2X:  w_aled_nxt = 3'b010;
            SPD_4X:  w_aled_nxt = 3'b100;
            default: w_aled_nxt = 3'b001;
        endcase
    end

    always_ff @(posedge Clk_50MHz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_speed       <= SPD_1X;
            r_aled        <= 3'b001;
            r_accel_pulse <= 1'b0;
            r_clr_pulse   <= 1'b0;
        end else begin
            r_speed       <= w_speed_nxt;
            r_aled        <= w_aled_nxt;
            r_accel_pulse <= w_press[2];
            r_clr_pulse   <= w_clr_nxt;
        end
    end

    assign Key_level   = w_level;
    assign Up_pulse    = r_rep_pulse[0];
    assign Down_pulse  = r_rep_pulse[1];
    assign Accel_pulse = r_accel_pulse;
    assign Speed_sel   = r_speed;
    assign ALed        = r_aled;
    assign Clr_pulse   = r_clr_pulse;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed self-checking bench for key_conditioner with DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=8.
// Cycle c counts rising edges after the stimulus change; outputs are sampled 1 ns after each edge.
module tb_key_conditioner;

    logic       clk;
    logic       rst_n;
    logic [2:0] key_n;
    logic [2:0] key_level;
    logic       up_pulse;
    logic       down_pulse;
    logic       accel_pulse;
    logic [1:0] speed_sel;
    logic [2:0] aled;
    logic       clr_pulse;

    int errors;
    int checks;

    key_conditioner #(
        .DEB_CYCLES (4),
        .REP_DELAY  (20),
        .REP_PERIOD (8)
    ) dut (
        .Clk_50MHz   (clk),
        .Rst_n       (rst_n),
        .Key_n       (key_n),
        .Key_level   (key_level),
        .Up_pulse    (up_pulse),
        .Down_pulse  (down_pulse),
        .Accel_pulse (accel_pulse),
        .Speed_sel   (speed_sel),
        .ALed        (aled),
        .Clr_pulse   (clr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_level"}, {5'd0, key_level}, 8'h00);
        chk({tag, "_up"}, {7'd0, up_pulse}, 8'h00);
        chk({tag, "_down"}, {7'd0, down_pulse}, 8'h00);
        chk({tag, "_accel"}, {7'd0, accel_pulse}, 8'h00);
        chk({tag, "_clr"}, {7'd0, clr_pulse}, 8'h00);
        chk({tag, "_speed"}, {6'd0, speed_sel}, 8'h00);
        chk({tag, "_aled"}, {5'd0, aled}, 8'h01);
    endtask

    logic [1:0] spd_tab [4];
    logic [2:0] led_tab [4];
    logic [1:0] spd_old;
    logic [1:0] spd_hold_end;

    initial begin
        errors = 0;
        checks = 0;
        spd_tab[0] = 2'd1; spd_tab[1] = 2'd2; spd_tab[2] = 2'd0; spd_tab[3] = 2'd1;
        led_tab[0] = 3'b010; led_tab[1] = 3'b100; led_tab[2] = 3'b001; led_tab[3] = 3'b010;

        // Reset state
        key_n = 3'b111;
        rst_n = 1'b0;
        tick(); tick();
        chk_idle_outputs("in_reset");
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk_idle_outputs("after_reset");

        // Up bounce: low for 3 edges only, must be discarded
        key_n = 3'b110;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk("bounce_up_pulse", {7'd0, up_pulse}, 8'h00);
            chk("bounce_level0", {7'd0, key_level[0]}, 8'h00);
            if (c == 3) key_n = 3'b111;
        end

        // Up press: pulse exactly at cycle 7, released after 10 cycles
        key_n = 3'b110;
        for (int c = 1; c <= 25; c++) begin
            tick();
            chk("up_press_pulse", {7'd0, up_pulse}, {7'd0, (c == 7)});
            chk("up_press_level0", {7'd0, key_level[0]}, {7'd0, (c >= 6 && c <= 15)});
            if (c == 10) key_n = 3'b111;
        end

        // Down held 60 cycles: initial pulse, delay, then periodic repeats
        key_n = 3'b101;
        for (int c = 1; c <= 75; c++) begin
            tick();
            chk("down_rep_pulse", {7'd0, down_pulse},
                {7'd0, (c == 7 || c == 27 || c == 35 || c == 43 || c == 51 || c == 59)});
            chk("down_rep_up", {7'd0, up_pulse}, 8'h00);
            chk("down_rep_level1", {7'd0, key_level[1]}, {7'd0, (c >= 6 && c <= 65)});
            if (c == 60) key_n = 3'b111;
        end

        // Accel pressed four times: speed 1,2,0,1
        spd_old = 2'd0;
        for (int p = 0; p < 4; p++) begin
            key_n = 3'b011;
            for (int c = 1; c <= 16; c++) begin
                tick();
                chk("accel_pulse", {7'd0, accel_pulse}, {7'd0, (c == 7)});
                chk("accel_speed", {6'd0, speed_sel}, {6'd0, (c >= 7) ? spd_tab[p] : spd_old});
                if (c >= 7) chk("accel_aled", {5'd0, aled}, {5'd0, led_tab[p]});
                if (c == 6) key_n = 3'b111;
            end
            spd_old = spd_tab[p];
        end

        // Up held, Down joins at cycle 10: no pulses while both are held
        key_n = 3'b110;
        for (int c = 1; c <= 80; c++) begin
            tick();
            chk("both_up", {7'd0, up_pulse}, {7'd0, (c == 7)});
            chk("both_down", {7'd0, down_pulse}, 8'h00);
            if (c == 30) chk("both_level", {5'd0, key_level}, 8'h03);
            if (c == 70) chk("both_level_after", {5'd0, key_level}, 8'h01);
            if (c == 10) key_n = 3'b100;
            if (c == 50) key_n = 3'b110;
        end
        key_n = 3'b111;
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk("both_release_up", {7'd0, up_pulse}, 8'h00);
        end
        key_n = 3'b110;
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk("both_rearm_up", {7'd0, up_pulse}, {7'd0, (c == 7)});
        end
        key_n = 3'b111;
        for (int c = 1; c <= 10; c++) tick();

        // Accel long hold starting from speed 1
`ifdef KEY_LONGPRESS_CLR_EN
        spd_hold_end = 2'd0;
`else
        spd_hold_end = 2'd2;
`endif
        key_n = 3'b011;
        for (int c = 1; c <= 70; c++) begin
            tick();
            chk("hold_accel_pulse", {7'd0, accel_pulse}, {7'd0, (c == 7)});
`ifdef KEY_LONGPRESS_CLR_EN
            chk("hold_clr", {7'd0, clr_pulse}, {7'd0, (c == 46)});
            chk("hold_speed", {6'd0, speed_sel}, {6'd0, (c < 7) ? 2'd1 : ((c < 46) ? 2'd2 : 2'd0)});
`else
            chk("hold_clr", {7'd0, clr_pulse}, 8'h00);
            chk("hold_speed", {6'd0, speed_sel}, {6'd0, (c < 7) ? 2'd1 : 2'd2});
`endif
            if (c == 60) key_n = 3'b111;
        end
        chk("hold_end_speed", {6'd0, speed_sel}, {6'd0, spd_hold_end});

        // Reset asserted mid-hold; Up still held pulses once after release
        key_n = 3'b110;
        for (int c = 1; c <= 10; c++) tick();
        chk("midhold_level_pre", {5'd0, key_level}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midhold_reset");
        tick(); tick(); tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk("midhold_up_pulse", {7'd0, up_pulse}, {7'd0, (c == 7)});
            chk("midhold_level0", {7'd0, key_level[0]}, {7'd0, (c >= 6)});
        end
        key_n = 3'b111;
        for (int c = 1; c <= 10; c++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
